// File: rtl/gbar_unit_if.sv
// Request/response bundle for the global barrier unit.
// The master side is the set of cores issuing arrivals; the slave side is gbar_unit.
interface gbar_unit_if #(
    parameter int NUM_REQS     = 4,
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 8,
    parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
);
    // Per-port arrival requests, packed port-major (port i at slice i*W +: W)
    logic [NUM_REQS-1:0]          req_valid;
    logic [NUM_REQS*NB_WIDTH-1:0] req_id;
    logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1;
    logic [NUM_REQS*NC_WIDTH-1:0] req_core_id;
    logic [NUM_REQS-1:0]          req_ready;

    // Broadcast release pulse and barrier occupancy
    logic                         rsp_valid;
    logic [NB_WIDTH-1:0]          rsp_id;
    logic [NUM_BARRIERS-1:0]      active_mask;

    modport master (
        output req_valid, req_id, req_size_m1, req_core_id,
        input  req_ready, rsp_valid, rsp_id, active_mask
    );

    modport slave (
        input  req_valid, req_id, req_size_m1, req_core_id,
        output req_ready, rsp_valid, rsp_id, active_mask
    );
endinterface

// File: rtl/gbar_unit.sv
// Global barrier unit: collects per-core arrivals on a set of barrier ids and
// broadcasts a one-cycle release pulse once the expected participant count is met.
// One request is accepted per cycle through a round-robin arbiter.
module gbar_unit #(
    parameter int NUM_REQS     = 4,
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 8,
    parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic         clk,
    input  logic         reset,
    gbar_unit_if.slave   bus
);

    localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int CNT_W = $clog2(NUM_CORES + 1);

    // Architectural state
    logic [NUM_CORES-1:0]    r_mask [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] r_active;
    logic [PTR_W-1:0]        r_ptr;
    logic                    r_rsp_valid;
    logic [NB_WIDTH-1:0]     r_rsp_id;

    // Per-port field views
    logic [NB_WIDTH-1:0]     w_port_id   [NUM_REQS];
    logic [NC_WIDTH-1:0]     w_port_size [NUM_REQS];
    logic [NC_WIDTH-1:0]     w_port_core [NUM_REQS];

    // Arbitration
    logic                    w_grant_valid;
    logic [PTR_W-1:0]        w_grant_idx;
    logic [PTR_W-1:0]        w_ptr_next;
    logic [NUM_REQS-1:0]     w_ready;
    logic                    w_accept;

    // Granted request and its effect on the addressed barrier
    logic [NB_WIDTH-1:0]     w_sel_id;
    logic [NC_WIDTH-1:0]     w_sel_size;
    logic [NC_WIDTH-1:0]     w_sel_core;
    logic                    w_in_range;
    logic                    w_update;
    logic [NUM_CORES-1:0]    w_cur_mask;
    logic [NUM_CORES-1:0]    w_next_mask;
    logic [CNT_W-1:0]        w_count;
    logic [NC_WIDTH:0]       w_target;
    logic                    w_release;

    // Next-state masks for every barrier
    logic [NUM_CORES-1:0]    w_mask_next [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] w_active_next;

    genvar gi;

    // Slice the packed request buses into per-port fields
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : g_port
            assign w_port_id[gi]   = bus.req_id[gi*NB_WIDTH +: NB_WIDTH];
            assign w_port_size[gi] = bus.req_size_m1[gi*NC_WIDTH +: NC_WIDTH];
            assign w_port_core[gi] = bus.req_core_id[gi*NC_WIDTH +: NC_WIDTH];
        end
    endgenerate

    // Round-robin search: first valid port at or after the pointer, wrapping
    always_comb begin
        int p;
        p             = 0;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            p = (int'(r_ptr) + k) % NUM_REQS;
            if (!w_grant_valid && bus.req_valid[p]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = PTR_W'(p);
            end
        end
    end

    // One-hot grant, forced low while in reset; pointer advances past the winner
    always_comb begin
        w_ready    = '0;
        w_ptr_next = r_ptr;
        if (w_grant_valid && !reset) begin
            w_ready[w_grant_idx] = 1'b1;
            if (32'(w_grant_idx) == NUM_REQS - 1) begin
                w_ptr_next = '0;
            end else begin
                w_ptr_next = w_grant_idx + 1'b1;
            end
        end
    end

    assign w_accept   = w_grant_valid && !reset;
    assign w_sel_id   = w_port_id[w_grant_idx];
    assign w_sel_size = w_port_size[w_grant_idx];
    assign w_sel_core = w_port_core[w_grant_idx];

    // Out-of-range ids or cores are consumed but leave the state untouched
    assign w_in_range = (32'(w_sel_id) < NUM_BARRIERS) && (32'(w_sel_core) < NUM_CORES);
    assign w_update   = w_accept && w_in_range;

    // Merge the arrival into the barrier's mask and test for completion.
    // The target uses the size of this request only; size of earlier arrivals is not kept.
    always_comb begin
        w_cur_mask  = '0;
        w_next_mask = '0;
        w_count     = '0;
        if (w_in_range) begin
            w_cur_mask = r_mask[w_sel_id];
        end
        w_next_mask = w_cur_mask | (NUM_CORES'(1) << w_sel_core);
        for (int i = 0; i < NUM_CORES; i++) begin
            w_count = w_count + CNT_W'(w_next_mask[i]);
        end
    end

    // Size is zero-extended before the increment so the target never wraps;
    // a target beyond NUM_CORES is unreachable and the barrier simply fills up.
    assign w_target  = {1'b0, w_sel_size} + 1'b1;
    assign w_release = w_update && (32'(w_count) == 32'(w_target));

    // Per-barrier next state: only the addressed barrier changes
    generate
        for (gi = 0; gi < NUM_BARRIERS; gi++) begin : g_bar
            assign w_mask_next[gi] = (w_update && (32'(w_sel_id) == gi))
                                   ? (w_release ? '0 : w_next_mask)
                                   : r_mask[gi];
            assign w_active_next[gi] = |w_mask_next[gi];
        end
    endgenerate

    // State update: masks, occupancy, arbitration pointer and release pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_mask[b] <= '0;
            end
            r_active    <= '0;
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_mask[b] <= w_mask_next[b];
            end
            r_active    <= w_active_next;
            r_ptr       <= w_ptr_next;
            r_rsp_valid <= w_release;
            if (w_release) begin
                r_rsp_id <= w_sel_id;
            end
        end
    end

    // Outputs are held quiet in any cycle with reset high, which also
    // swallows a release pulse that would otherwise land in that cycle.
    assign bus.req_ready   = w_ready;
    assign bus.rsp_valid   = r_rsp_valid && !reset;
    assign bus.rsp_id      = reset ? '0 : r_rsp_id;
    assign bus.active_mask = reset ? '0 : r_active;

endmodule

// File: tb/tb_gbar_unit.sv
// Directed bench for gbar_unit with default parameters (4 ports, 4 cores, 8 barriers).
module tb_gbar_unit;

    localparam int NR  = 4;
    localparam int NC  = 4;
    localparam int NB  = 8;
    localparam int NCW = 2;
    localparam int NBW = 3;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    gbar_unit_if #(
        .NUM_REQS(NR), .NUM_CORES(NC), .NUM_BARRIERS(NB),
        .NC_WIDTH(NCW), .NB_WIDTH(NBW)
    ) gbar_bus ();

    gbar_unit #(
        .NUM_REQS(NR), .NUM_CORES(NC), .NUM_BARRIERS(NB),
        .NC_WIDTH(NCW), .NB_WIDTH(NBW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (gbar_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("[TB] %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic idle();
        gbar_bus.req_valid   = '0;
        gbar_bus.req_id      = '0;
        gbar_bus.req_size_m1 = '0;
        gbar_bus.req_core_id = '0;
    endtask

    task automatic drive(input int p, input int id, input int s, input int c);
        gbar_bus.req_valid[p]                = 1'b1;
        gbar_bus.req_id[p*NBW +: NBW]        = NBW'(id);
        gbar_bus.req_size_m1[p*NCW +: NCW]   = NCW'(s);
        gbar_bus.req_core_id[p*NCW +: NCW]   = NCW'(c);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        idle();

        // Reset state, with a request pending that must not be granted
        drive(0, 3, 3, 0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(gbar_bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(gbar_bus.rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(gbar_bus.rsp_id), 32'h0);
        check("rst_active", 32'(gbar_bus.active_mask), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic barrier: cores 0..2 then 3 at id 3, size 4, ports 0..3
        idle(); drive(0, 3, 3, 0); #1;
        check("b33_ready0", 32'(gbar_bus.req_ready), 32'h1);
        tick();
        check("b33_rsp_a", 32'(gbar_bus.rsp_valid), 32'h0);
        check("b33_active_a", 32'(gbar_bus.active_mask), 32'h08);
        idle(); drive(1, 3, 3, 1); #1;
        check("b33_ready1", 32'(gbar_bus.req_ready), 32'h2);
        tick();
        check("b33_rsp_b", 32'(gbar_bus.rsp_valid), 32'h0);
        idle(); drive(2, 3, 3, 2); #1;
        check("b33_ready2", 32'(gbar_bus.req_ready), 32'h4);
        tick();
        check("b33_rsp_c", 32'(gbar_bus.rsp_valid), 32'h0);
        check("b33_active_c", 32'(gbar_bus.active_mask), 32'h08);
        idle(); drive(3, 3, 3, 3); #1;
        check("b33_ready3", 32'(gbar_bus.req_ready), 32'h8);
        tick();
        check("b33_rsp_d", 32'(gbar_bus.rsp_valid), 32'h1);
        check("b33_rsp_id", 32'(gbar_bus.rsp_id), 32'h3);
        check("b33_active_d", 32'(gbar_bus.active_mask), 32'h0);
        idle(); tick();
        check("b33_rsp_after", 32'(gbar_bus.rsp_valid), 32'h0);

        // All ports valid, id 0, size 4: grants 0,1,2,3 then release
        idle();
        for (int p = 0; p < NR; p++) drive(p, 0, 3, p);
        for (int k = 0; k < NR; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), 32'(gbar_bus.req_ready), 32'(1 << k));
            tick();
            check($sformatf("rr_rsp_%0d", k), 32'(gbar_bus.rsp_valid), (k == NR - 1) ? 32'h1 : 32'h0);
        end
        check("rr_rsp_id", 32'(gbar_bus.rsp_id), 32'h0);
        idle(); tick();
        check("rr_rsp_after", 32'(gbar_bus.rsp_valid), 32'h0);

        // Duplicate arrival: core 1 twice at id 2 size 2, then core 0
        idle(); drive(0, 2, 1, 1); tick();
        check("dup_rsp_a", 32'(gbar_bus.rsp_valid), 32'h0);
        idle(); drive(0, 2, 1, 1); #1;
        check("dup_ready", 32'(gbar_bus.req_ready), 32'h1);
        tick();
        check("dup_rsp_b", 32'(gbar_bus.rsp_valid), 32'h0);
        check("dup_active", 32'(gbar_bus.active_mask), 32'h04);
        idle(); drive(0, 2, 1, 0); tick();
        check("dup_rsp_c", 32'(gbar_bus.rsp_valid), 32'h1);
        check("dup_rsp_id", 32'(gbar_bus.rsp_id), 32'h2);
        check("dup_active_c", 32'(gbar_bus.active_mask), 32'h0);

        // Interleaved ids 1 and 5, size 2 each
        idle(); drive(0, 1, 1, 0); tick();
        check("il_rsp_a", 32'(gbar_bus.rsp_valid), 32'h0);
        idle(); drive(0, 5, 1, 0); tick();
        check("il_rsp_b", 32'(gbar_bus.rsp_valid), 32'h0);
        check("il_active_b", 32'(gbar_bus.active_mask), 32'h22);
        idle(); drive(0, 1, 1, 1); tick();
        check("il_rsp_c", 32'(gbar_bus.rsp_valid), 32'h1);
        check("il_rsp_id_c", 32'(gbar_bus.rsp_id), 32'h1);
        check("il_active_c", 32'(gbar_bus.active_mask), 32'h20);
        idle(); drive(0, 5, 1, 1); tick();
        check("il_rsp_d", 32'(gbar_bus.rsp_valid), 32'h1);
        check("il_rsp_id_d", 32'(gbar_bus.rsp_id), 32'h5);
        check("il_active_d", 32'(gbar_bus.active_mask), 32'h0);

        // Pointer is 1: ports 0 and 2 valid -> port 2 first, then wrap to port 0
        idle(); drive(0, 3, 3, 0); drive(2, 3, 3, 1); #1;
        check("wrap_ready_a", 32'(gbar_bus.req_ready), 32'h4);
        tick(); #1;
        check("wrap_ready_b", 32'(gbar_bus.req_ready), 32'h1);
        tick();
        idle();

        // Reset mid-round at id 4 (size 3): partial arrivals discarded
        drive(0, 4, 2, 0); tick();
        idle(); drive(0, 4, 2, 1); tick();
        check("mr_active_pre", 32'(gbar_bus.active_mask), 32'h18);
        reset = 1'b1; #1;
        check("mr_ready_rst", 32'(gbar_bus.req_ready), 32'h0);
        check("mr_active_rst", 32'(gbar_bus.active_mask), 32'h0);
        tick();
        reset = 1'b0;
        idle(); drive(0, 4, 2, 2); tick();
        check("mr_rsp", 32'(gbar_bus.rsp_valid), 32'h0);
        check("mr_active_post", 32'(gbar_bus.active_mask), 32'h10);

        // Release of id 6 then a fresh arrival in the following cycle
        idle(); drive(0, 6, 0, 2); tick();
        check("fr_rsp_a", 32'(gbar_bus.rsp_valid), 32'h1);
        check("fr_rsp_id_a", 32'(gbar_bus.rsp_id), 32'h6);
        idle(); drive(0, 6, 1, 1); tick();
        check("fr_rsp_b", 32'(gbar_bus.rsp_valid), 32'h0);
        check("fr_active_b", 32'(gbar_bus.active_mask), 32'h50);

        // Release pulse due in a reset cycle is suppressed
        idle(); drive(0, 7, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle();
        @(negedge clk);
        check("sup_rsp", 32'(gbar_bus.rsp_valid), 32'h0);
        check("sup_rsp_id", 32'(gbar_bus.rsp_id), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("sup_rsp_after", 32'(gbar_bus.rsp_valid), 32'h0);
        check("sup_active_after", 32'(gbar_bus.active_mask), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
